// File: rtl/pll_clken_sequencer.sv
// Sequences PLL output clock enables one bit at a time once lock has been stable.
// Optional lock watchdog is built when PLL_SEQ_LOCK_WATCHDOG_EN is defined.
//
// state     | meaning
// WAIT_LOCK | enables held off, qualifying synchronized lock for LOCK_STABLE_CYC cycles
// RUN       | lock qualified, enclk walks toward clk_req one bit per gap window
module pll_clken_sequencer #(
    parameter int NCLK            = 5,
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int GAP_CYC         = 16,
    parameter int TIMEOUT_CYC     = 65536
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pll_lock,
    input  logic [NCLK-1:0] clk_req,
    output logic [NCLK-1:0] enclk,
    output logic            seq_ready,
    output logic            seq_busy,
    output logic            lock_lost,
    output logic            lock_timeout
);

    localparam int SW = (LOCK_STABLE_CYC < 2) ? 1 : $clog2(LOCK_STABLE_CYC);
    localparam int GW = (GAP_CYC < 1) ? 1 : $clog2(GAP_CYC + 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYC - 1);
    localparam logic [GW-1:0] GAP_LOAD    = GW'(GAP_CYC);

    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } state_t;

    state_t          state;
    logic            sync1;
    logic            lock_s;
    logic [SW-1:0]   stable_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [NCLK-1:0] on_mask;
    logic [NCLK-1:0] off_mask;
    logic [NCLK-1:0] toggle;
    logic            found;

    assign on_mask  = clk_req & ~enclk;
    assign off_mask = enclk & ~clk_req;

    // Turn-ons win over turn-offs: lowest pending enable first, else highest pending disable.
    always_comb begin
        toggle = '0;
        found  = 1'b0;
        for (int i = 0; i < NCLK; i++) begin
            if (!found && on_mask[i]) begin
                toggle[i] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int i = NCLK - 1; i >= 0; i--) begin
            if (!found && off_mask[i]) begin
                toggle[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_LOCK;
            sync1      <= 1'b0;
            lock_s     <= 1'b0;
            stable_cnt <= '0;
            gap_cnt    <= '0;
            enclk      <= '0;
            seq_ready  <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            sync1     <= pll_lock;
            lock_s    <= sync1;
            lock_lost <= 1'b0;
            case (state)
                WAIT_LOCK: begin
                    enclk   <= '0;
                    gap_cnt <= '0;
                    if (!lock_s) begin
                        stable_cnt <= '0;
                    end else if (stable_cnt == STABLE_LAST) begin
                        state      <= RUN;
                        seq_ready  <= 1'b1;
                        stable_cnt <= '0;
                    end else begin
                        stable_cnt <= stable_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state      <= WAIT_LOCK;
                        enclk      <= '0;
                        seq_ready  <= 1'b0;
                        lock_lost  <= 1'b1;
                        gap_cnt    <= '0;
                        stable_cnt <= '0;
                    end else if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (clk_req != enclk) begin
                        enclk   <= enclk ^ toggle;
                        gap_cnt <= GAP_LOAD;
                    end
                end
                default: state <= WAIT_LOCK;
            endcase
        end
    end

    assign seq_busy = (state == RUN) && ((enclk != clk_req) || (gap_cnt != '0));

`ifdef PLL_SEQ_LOCK_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT_CYC);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYC - 1);

    logic [WW-1:0] wd_cnt;
    logic          timeout_flag;

    // Counter saturates at the limit; the flag only clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else if (state == RUN) begin
            wd_cnt <= '0;
        end else begin
            if (wd_cnt != WD_LIMIT) wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == WD_LAST) timeout_flag <= 1'b1;
        end
    end

    assign lock_timeout = timeout_flag;
`else
    assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pll_clken_sequencer.sv
// Directed bench for pll_clken_sequencer with NCLK=5, LOCK_STABLE_CYC=8, GAP_CYC=4, TIMEOUT_CYC=32.
module tb_pll_clken_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic [4:0] clk_req;
    logic [4:0] enclk;
    logic       seq_ready;
    logic       seq_busy;
    logic       lock_lost;
    logic       lock_timeout;

    int n_checks = 0;
    int n_errors = 0;

    pll_clken_sequencer #(
        .NCLK(5),
        .LOCK_STABLE_CYC(8),
        .GAP_CYC(4),
        .TIMEOUT_CYC(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pll_lock(pll_lock),
        .clk_req(clk_req),
        .enclk(enclk),
        .seq_ready(seq_ready),
        .seq_busy(seq_busy),
        .lock_lost(lock_lost),
        .lock_timeout(lock_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Assert reset, then release it 1 unit after a rising edge (edge 0).
    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n    = 1'b0;
        pll_lock = 1'b1;
        clk_req  = 5'b00000;
        #3;
        check_eq("rst_enclk", enclk, 5'b00000);
        check_eq("rst_ready", seq_ready, 1'b0);
        check_eq("rst_busy", seq_busy, 1'b0);
        check_eq("rst_lost", lock_lost, 1'b0);
        check_eq("rst_timeout", lock_timeout, 1'b0);

        // Bring-up: 2 sync edges, then 8 qualifying edges.
        do_reset();
        step(9);
        check_eq("ready_early", seq_ready, 1'b0);
        check_eq("busy_wait", seq_busy, 1'b0);
        step(2);
        check_eq("ready_up", seq_ready, 1'b1);
        check_eq("enclk_idle", enclk, 5'b00000);
        check_eq("busy_idle", seq_busy, 1'b0);

        // Ascending enable with 5-cycle spacing.
        clk_req = 5'b10101;
        step(1);
        check_eq("on_1", enclk, 5'b00001);
        check_eq("on_busy", seq_busy, 1'b1);
        step(4);
        check_eq("on_hold", enclk, 5'b00001);
        step(1);
        check_eq("on_2", enclk, 5'b00101);
        step(5);
        check_eq("on_3", enclk, 5'b10101);
        step(3);
        check_eq("on_gap_busy", seq_busy, 1'b1);
        step(1);
        check_eq("on_done_busy", seq_busy, 1'b0);

        // Descending disable.
        clk_req = 5'b00000;
        step(1);
        check_eq("off_1", enclk, 5'b00101);
        step(5);
        check_eq("off_2", enclk, 5'b00001);
        step(5);
        check_eq("off_3", enclk, 5'b00000);
        step(4);
        check_eq("off_busy", seq_busy, 1'b0);

        // Request change during gap is picked up when the gap expires.
        clk_req = 5'b00001;
        step(1);
        check_eq("gap_a", enclk, 5'b00001);
        step(2);
        clk_req = 5'b00011;
        step(2);
        check_eq("gap_hold", enclk, 5'b00001);
        check_eq("gap_busy", seq_busy, 1'b1);
        step(1);
        check_eq("gap_b", enclk, 5'b00011);

        // Fill to 11111, then drop lock.
        clk_req = 5'b11111;
        step(15);
        check_eq("fill", enclk, 5'b11111);
        pll_lock = 1'b0;
        step(2);
        check_eq("loss_hold", enclk, 5'b11111);
        check_eq("loss_nopulse", lock_lost, 1'b0);
        step(1);
        check_eq("loss_enclk", enclk, 5'b00000);
        check_eq("loss_pulse", lock_lost, 1'b1);
        check_eq("loss_ready", seq_ready, 1'b0);
        step(1);
        check_eq("loss_pulse_end", lock_lost, 1'b0);
        check_eq("loss_busy", seq_busy, 1'b0);

        // One-cycle lock glitch while the stable count sits at 6.
        clk_req  = 5'b00000;
        pll_lock = 1'b1;
        do_reset();
        step(6);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(4);
        check_eq("glitch_e11", seq_ready, 1'b0);
        step(4);
        check_eq("glitch_e15", seq_ready, 1'b0);
        step(3);
        check_eq("glitch_ready", seq_ready, 1'b1);

        // Asynchronous reset clears enclk without a clock edge.
        clk_req = 5'b00001;
        step(1);
        check_eq("async_pre", enclk, 5'b00001);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_enclk", enclk, 5'b00000);
        check_eq("async_ready", seq_ready, 1'b0);

        // No enable before LOCK_STABLE_CYC+2 edges after release.
        clk_req = 5'b11111;
        step(1);
        rst_n = 1'b1;
        step(10);
        check_eq("restart_quiet", enclk, 5'b00000);
        step(1);
        check_eq("restart_first", enclk, 5'b00001);

        // Lock watchdog.
        pll_lock = 1'b0;
        clk_req  = 5'b00000;
        do_reset();
`ifdef PLL_SEQ_LOCK_WATCHDOG_EN
        step(31);
        check_eq("wd_before", lock_timeout, 1'b0);
        step(1);
        check_eq("wd_set", lock_timeout, 1'b1);
        pll_lock = 1'b1;
        step(15);
        check_eq("wd_sticky", lock_timeout, 1'b1);
        check_eq("wd_ready", seq_ready, 1'b1);
`else
        step(40);
        check_eq("wd_off", lock_timeout, 1'b0);
        pll_lock = 1'b1;
        step(15);
        check_eq("wd_off_run", lock_timeout, 1'b0);
        check_eq("wd_off_ready", seq_ready, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pll_clken_sequencer.md
PLL_CLKEN_SEQUENCER -- requirements
Module: pll_clken_sequencer

Interface
REQ-001 Parameter NCLK, default 5: number of PLL output clock enables sequenced.
REQ-002 Parameter LOCK_STABLE_CYC, default 1024: consecutive synchronized-lock cycles required before enables may assert.
REQ-003 Parameter GAP_CYC, default 16: minimum idle cycles between two successive enable-bit changes.
REQ-004 Parameter TIMEOUT_CYC, default 65536: lock watchdog limit; used only when the Configuration macro is defined.
REQ-005 Port clk  input  1  single system clock; all logic synchronous to it.
REQ-006 Port rst_n  input  1  asynchronous active-low reset.
REQ-007 Port pll_lock  input  1  PLL LOCK, asynchronous to clk.
REQ-008 Port clk_req  input  NCLK  desired enable mask, level, synchronous to clk.
REQ-009 Port enclk  output  NCLK  registered drive to PLL ENCLK0..ENCLK(NCLK-1).
REQ-010 Port seq_ready  output  1  high while in RUN state.
REQ-011 Port seq_busy  output  1  high while enclk differs from clk_req or gap counter is nonzero.
REQ-012 Port lock_lost  output  1  one-cycle pulse on lock loss in RUN.
REQ-013 Port lock_timeout  output  1  sticky watchdog flag (macro-dependent, see REQ-030).

Function
REQ-014 pll_lock shall pass a 2-flop synchronizer to form lock_s before any use.
REQ-015 States shall be WAIT_LOCK and RUN only.
REQ-016 WAIT_LOCK: enclk all zero; stable counter increments each cycle lock_s=1, clears to 0 when lock_s=0.
REQ-017 WAIT_LOCK -> RUN when stable counter reaches LOCK_STABLE_CYC-1 with lock_s=1; seq_ready rises the following cycle.
REQ-018 RUN, gap counter 0, clk_req != enclk: enclk changes exactly one bit on the next clock edge; gap counter loads GAP_CYC.
REQ-019 Bit selection: if any bit requires turn-on, set the lowest such index; otherwise clear the highest index requiring turn-off (enable before disable; enable ascending, disable descending).
REQ-020 Gap counter shall decrement to 0 each cycle when nonzero; no enclk change while nonzero; clk_req changes during gap are re-evaluated when it reaches 0.
REQ-021 clk_req == enclk with gap counter 0: no change, seq_busy=0.
REQ-022 RUN with lock_s=0: next edge clears all enclk, pulses lock_lost for one cycle, clears gap and stable counters, enters WAIT_LOCK; takes priority over REQ-018.
REQ-023 GAP_CYC=0 shall permit one bit change per cycle.
REQ-024 Counters shall be sized by $clog2 of their limits and shall not wrap.

Reset
REQ-025 rst_n low shall asynchronously force WAIT_LOCK, enclk=0, seq_ready=0, seq_busy=0, lock_lost=0, lock_timeout=0, all counters and synchronizer flops 0.
REQ-026 Reset deassertion mid-sequence shall restart from WAIT_LOCK; no enclk asserts before LOCK_STABLE_CYC+2 cycles after release.
REQ-027 seq_busy shall be 0 in WAIT_LOCK.

Configuration
REQ-028 Macro PLL_SEQ_LOCK_WATCHDOG_EN selects the lock watchdog.
REQ-029 Defined: a watchdog counter counts cycles in WAIT_LOCK, cleared on entering RUN; reaching TIMEOUT_CYC sets lock_timeout, sticky until rst_n.
REQ-030 Undefined: no watchdog logic; lock_timeout tied 0.

Verification (LOCK_STABLE_CYC=8, GAP_CYC=4, NCLK=5)
REQ-031 Reset release, pll_lock=1, clk_req=5'b00000 -> seq_ready=1 at cycle 2+8+1; enclk stays 0; seq_busy=0.
REQ-032 In RUN, clk_req=5'b10101 -> enclk 00001, 00101, 10101 on edges 5 cycles apart; seq_busy falls after final gap.
REQ-033 From enclk=10101, clk_req=5'b00000 -> clears bit4, bit2, bit0 in that order, 5 cycles apart.
REQ-034 pll_lock glitches low 1 cycle at stable count 6 -> counter restarts; seq_ready delayed by full 8 cycles; in RUN with enclk=11111, pll_lock low -> enclk=0 and lock_lost=1 for exactly one cycle, 3 cycles later.
REQ-035 Macro defined, TIMEOUT_CYC=32, pll_lock=0 -> lock_timeout=1 at cycle 32 and stays 1 after pll_lock rises; macro undefined -> lock_timeout=0 always.
REQ-036 clk_req changes 00001->00011 during gap -> bit1 sets exactly when gap expires; rst_n pulsed low mid-sequence -> enclk=0 immediately (asynchronous).
